// File: rtl/divider.sv
// -----------------------------------------------------------------------------
// divider
//
// Purpose:
//    Iterative 32-bit integer divider covering signed/unsigned quotient and
//    remainder (DIV, DIVU, REM, REMU). Operand magnitudes are divided with a
//    radix-2 restoring algorithm, one quotient bit per clock. The sign of the
//    result is applied in a separate FIX cycle. Divide-by-zero and signed
//    overflow (0x80000000 / -1) have fixed architectural results. With
//    EARLY_OUT=1 these results are returned straight from IDLE.
//
// Parameters:
//    EARLY_OUT  1: divide-by-zero / overflow finish at the acceptance edge
//               0: every operation takes the full iterative latency
//
// Ports:
//    clk        in   rising-edge clock
//    reset_n    in   asynchronous active-low reset
//    in_valid   in   request valid
//    in_ready   out  request can be accepted (IDLE only)
//    A          in   [31:0] dividend
//    B          in   [31:0] divisor
//    op         in   [1:0] 00 DIV, 01 DIVU, 10 REM, 11 REMU
//    out_valid  out  Out holds a completed result (DONE)
//    out_ready  in   consumer takes the result
//    Out        out  [31:0] quotient or remainder
//    busy       out  high in every state except IDLE
// -----------------------------------------------------------------------------
module divider #(
   parameter bit EARLY_OUT = 1'b1
) (
   input  logic        clk,
   input  logic        reset_n,
   input  logic        in_valid,
   output logic        in_ready,
   input  logic [31:0] A,
   input  logic [31:0] B,
   input  logic [1:0]  op,
   output logic        out_valid,
   input  logic        out_ready,
   output logic [31:0] Out,
   output logic        busy
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      BUSY = 2'd1,
      FIX  = 2'd2,
      DONE = 2'd3
   } state_t;

   localparam logic [31:0] INT_MIN = 32'h8000_0000;
   localparam logic [31:0] ALL_ONE = 32'hFFFF_FFFF;

   // ---------------------------------------------------------------------------
   // State and datapath registers
   // ---------------------------------------------------------------------------
   state_t      state_q, state_d;
   logic [5:0]  cnt_q, cnt_d;           // iteration counter, ends at 32
   logic [31:0] quo_q, quo_d;           // dividend magnitude shifting into quotient
   logic [31:0] rem_q, rem_d;           // partial remainder
   logic [31:0] div_q, div_d;           // divisor magnitude
   logic        is_rem_q, is_rem_d;     // remainder requested
   logic        neg_quo_q, neg_quo_d;   // quotient must be negated
   logic        neg_rem_q, neg_rem_d;   // remainder must be negated
   logic        spec_q, spec_d;         // divide-by-zero / overflow case
   logic [31:0] spec_val_q, spec_val_d; // fixed result for that case
   logic [31:0] out_q, out_d;

   // ---------------------------------------------------------------------------
   // Request decode (only used at the acceptance edge)
   // ---------------------------------------------------------------------------
   logic        req_signed;
   logic        req_rem;
   logic        a_neg;
   logic        b_neg;
   logic [31:0] a_mag;
   logic [31:0] b_mag;
   logic        div_zero;
   logic        overflow;
   logic        special;
   logic [31:0] special_val;

   always_comb begin
      req_signed = ~op[0];
      req_rem    = op[1];
      a_neg      = req_signed & A[31];
      b_neg      = req_signed & B[31];
      a_mag      = a_neg ? (~A + 32'd1) : A;
      b_mag      = b_neg ? (~B + 32'd1) : B;
      div_zero   = (B == 32'd0);
      overflow   = req_signed & (A == INT_MIN) & (B == ALL_ONE);
      special    = div_zero | overflow;
      if (div_zero) begin
         special_val = req_rem ? A : ALL_ONE;
      end else begin
         special_val = req_rem ? 32'd0 : INT_MIN;
      end
   end

   // ---------------------------------------------------------------------------
   // One restoring step: shift the next dividend bit into the partial
   // remainder and subtract the divisor when it fits. The shifted value can
   // exceed 32 bits, so the compare is done at 33 bits; when it succeeds the
   // difference is below the divisor and fits in 32 bits.
   // ---------------------------------------------------------------------------
   logic [32:0] rem_shift;
   logic        step_fits;
   logic [31:0] step_diff;

   always_comb begin
      rem_shift = {rem_q, quo_q[31]};
      step_fits = (rem_shift >= {1'b0, div_q});
      step_diff = rem_shift[31:0] - div_q;
   end

   // ---------------------------------------------------------------------------
   // Sign correction for the FIX cycle
   // ---------------------------------------------------------------------------
   logic [31:0] res_mag;
   logic        res_neg;
   logic [31:0] res_final;

   always_comb begin
      res_mag   = is_rem_q ? rem_q : quo_q;
      res_neg   = is_rem_q ? neg_rem_q : neg_quo_q;
      res_final = res_neg ? (~res_mag + 32'd1) : res_mag;
   end

   // ---------------------------------------------------------------------------
   // Next-state / datapath logic
   // ---------------------------------------------------------------------------
   always_comb begin
      state_d    = state_q;
      cnt_d      = cnt_q;
      quo_d      = quo_q;
      rem_d      = rem_q;
      div_d      = div_q;
      is_rem_d   = is_rem_q;
      neg_quo_d  = neg_quo_q;
      neg_rem_d  = neg_rem_q;
      spec_d     = spec_q;
      spec_val_d = spec_val_q;
      out_d      = out_q;

      unique case (state_q)
         IDLE: begin
            if (in_valid) begin
               cnt_d      = 6'd0;
               quo_d      = a_mag;
               rem_d      = 32'd0;
               div_d      = b_mag;
               is_rem_d   = req_rem;
               neg_quo_d  = a_neg ^ b_neg;
               neg_rem_d  = a_neg;
               spec_d     = special;
               spec_val_d = special_val;
               if (EARLY_OUT && special) begin
                  out_d   = special_val;
                  state_d = DONE;
               end else begin
                  state_d = BUSY;
               end
            end
         end

         BUSY: begin
            rem_d = step_fits ? step_diff : rem_shift[31:0];
            quo_d = {quo_q[30:0], step_fits};
            cnt_d = cnt_q + 6'd1;
            // The 32nd step is taken with cnt_q == 31; the counter stops at 32.
            if (cnt_q == 6'd31) begin
               state_d = FIX;
            end
         end

         FIX: begin
            out_d   = spec_q ? spec_val_q : res_final;
            state_d = DONE;
         end

         DONE: begin
            if (out_ready) begin
               state_d = IDLE;
            end
         end

         default: begin
            state_d = IDLE;
         end
      endcase
   end

   // ---------------------------------------------------------------------------
   // Registers
   // ---------------------------------------------------------------------------
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q    <= IDLE;
         cnt_q      <= 6'd0;
         quo_q      <= 32'd0;
         rem_q      <= 32'd0;
         div_q      <= 32'd0;
         is_rem_q   <= 1'b0;
         neg_quo_q  <= 1'b0;
         neg_rem_q  <= 1'b0;
         spec_q     <= 1'b0;
         spec_val_q <= 32'd0;
         out_q      <= 32'd0;
      end else begin
         state_q    <= state_d;
         cnt_q      <= cnt_d;
         quo_q      <= quo_d;
         rem_q      <= rem_d;
         div_q      <= div_d;
         is_rem_q   <= is_rem_d;
         neg_quo_q  <= neg_quo_d;
         neg_rem_q  <= neg_rem_d;
         spec_q     <= spec_d;
         spec_val_q <= spec_val_d;
         out_q      <= out_d;
      end
   end

   // ---------------------------------------------------------------------------
   // Outputs. in_ready is gated by reset_n so it is low while reset is held.
   // ---------------------------------------------------------------------------
   assign in_ready  = (state_q == IDLE) & reset_n;
   assign out_valid = (state_q == DONE);
   assign busy      = (state_q != IDLE);
   assign Out       = out_q;

endmodule

// File: tb/tb_divider.sv
// -----------------------------------------------------------------------------
// tb_divider
//
// Purpose:
//    Self-checking bench for divider (EARLY_OUT=1). A driver issues directed
//    and random requests; a single monitor on the falling edge predicts each
//    result and its latency from plain integer arithmetic and checks the
//    handshake, stability and reset behaviour every cycle.
// -----------------------------------------------------------------------------
module tb_divider;

   localparam bit EARLY = 1'b1;
   localparam logic [1:0] OP_DIV  = 2'b00;
   localparam logic [1:0] OP_DIVU = 2'b01;
   localparam logic [1:0] OP_REM  = 2'b10;
   localparam logic [1:0] OP_REMU = 2'b11;

   logic        clk;
   logic        reset_n;
   logic        in_valid;
   logic        in_ready;
   logic [31:0] A;
   logic [31:0] B;
   logic [1:0]  op;
   logic        out_valid;
   logic        out_ready;
   logic [31:0] Out;
   logic        busy;

   divider #(.EARLY_OUT(EARLY)) dut (
      .clk       (clk),
      .reset_n   (reset_n),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .A         (A),
      .B         (B),
      .op        (op),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .Out       (Out),
      .busy      (busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int n_checks = 0;
   int n_errors = 0;
   int cyc = 0;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
      n_checks++;
      if (act !== req) begin
         n_errors++;
         $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, req, cyc);
      end
   endtask

   // ---------------------------------------------------------------------------
   // Reference model: plain integer arithmetic on the request
   // ---------------------------------------------------------------------------
   function automatic bit is_special(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
      return (b == 32'd0) || (!o[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF);
   endfunction

   function automatic logic [31:0] model(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
      int sa;
      int sb;
      sa = a;
      sb = b;
      if (b == 32'd0) return o[1] ? a : 32'hFFFF_FFFF;
      case (o)
         OP_DIVU: return a / b;
         OP_REMU: return a % b;
         OP_DIV: begin
            if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'h8000_0000;
            return 32'(sa / sb);
         end
         default: begin
            if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'd0;
            return 32'(sa % sb);
         end
      endcase
   endfunction

   // ---------------------------------------------------------------------------
   // Monitor: predicts at acceptance, checks every cycle on the falling edge
   // ---------------------------------------------------------------------------
   logic [31:0] exp_out;
   int          exp_lat;
   int          acc_cyc;
   bit          inflight = 0;
   bit          was_valid = 0;
   bit          after_xfer = 0;
   logic [31:0] last_out = 32'd0;

   always @(negedge clk) begin
      if (!reset_n) begin
         check("rst_in_ready", {31'd0, in_ready}, 32'd0);
         check("rst_out_valid", {31'd0, out_valid}, 32'd0);
         check("rst_busy", {31'd0, busy}, 32'd0);
         check("rst_out", Out, 32'd0);
         inflight   = 0;
         was_valid  = 0;
         after_xfer = 0;
         last_out   = 32'd0;
      end else begin
         if (after_xfer) begin
            check("idle_after_xfer_ready", {31'd0, in_ready}, 32'd1);
            check("idle_after_xfer_busy", {31'd0, busy}, 32'd0);
            check("idle_out_retained", Out, last_out);
            after_xfer = 0;
         end
         if (inflight && !out_valid) begin
            check("busy_in_ready_low", {31'd0, in_ready}, 32'd0);
            check("busy_high", {31'd0, busy}, 32'd1);
            check("busy_out_retained", Out, last_out);
         end
         if (out_valid) begin
            if (!inflight) begin
               check("spurious_out_valid", {31'd0, out_valid}, 32'd0);
            end else begin
               if (!was_valid) begin
                  check("result", Out, exp_out);
                  check("latency", cyc - acc_cyc, exp_lat);
               end else begin
                  check("done_out_stable", Out, last_out);
               end
               check("done_in_ready_low", {31'd0, in_ready}, 32'd0);
               check("done_busy", {31'd0, busy}, 32'd1);
               last_out  = Out;
               was_valid = 1;
               if (out_ready) begin
                  inflight   = 0;
                  was_valid  = 0;
                  after_xfer = 1;
               end
            end
         end
         if (in_valid && in_ready) begin
            exp_out  = model(op, A, B);
            // Latency in edges from the acceptance edge to the first cycle
            // with out_valid: early-out results appear right after acceptance.
            exp_lat  = (EARLY && is_special(op, A, B)) ? 0 : 33;
            acc_cyc  = cyc + 1;
            inflight = 1;
         end
      end
   end

   // ---------------------------------------------------------------------------
   // Driver (inputs change 1 time unit after the rising edge)
   // ---------------------------------------------------------------------------
   task automatic do_op(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                        input int hold);
      int t;
      t = 0;
      while (!in_ready && t < 200) begin
         @(posedge clk); #1;
         t++;
      end
      if (!in_ready) check("timeout_in_ready", {31'd0, in_ready}, 32'd1);
      in_valid = 1'b1;
      op = o;
      A  = a;
      B  = b;
      @(posedge clk); #1;
      t = 0;
      // While the operation runs, scramble inputs that must be ignored.
      while (!out_valid && t < 100) begin
         in_valid  = 1'($urandom_range(0, 1));
         out_ready = 1'($urandom_range(0, 1));
         A  = $urandom;
         B  = $urandom;
         op = 2'($urandom_range(0, 3));
         @(posedge clk); #1;
         t++;
      end
      in_valid = 1'b0;
      if (!out_valid) begin
         check("timeout_out_valid", {31'd0, out_valid}, 32'd1);
         out_ready = 1'b0;
         return;
      end
      if (hold > 0) begin
         out_ready = 1'b0;
         repeat (hold) begin
            in_valid = 1'($urandom_range(0, 1));
            A = $urandom;
            @(posedge clk); #1;
         end
         in_valid = 1'b0;
      end
      out_ready = 1'b1;
      @(posedge clk); #1;
      out_ready = 1'b0;
   endtask

   task automatic rand_op();
      logic [1:0]  o;
      logic [31:0] a;
      logic [31:0] b;
      o = 2'($urandom_range(0, 3));
      case ($urandom_range(0, 5))
         0: begin a = $urandom; b = 32'd0; end
         1: begin a = 32'h8000_0000; b = 32'hFFFF_FFFF; end
         2: begin
            a = $urandom_range(0, 1000);
            b = $urandom_range(1, 50);
            if ($urandom_range(0, 1) == 1) a = ~a + 32'd1;
            if ($urandom_range(0, 1) == 1) b = ~b + 32'd1;
         end
         3: begin a = $urandom; b = $urandom_range(1, 300); end
         default: begin a = $urandom; b = $urandom; end
      endcase
      do_op(o, a, b, $urandom_range(0, 3));
   endtask

   initial begin
      reset_n   = 1'b0;
      in_valid  = 1'b0;
      out_ready = 1'b0;
      A  = 32'd0;
      B  = 32'd0;
      op = 2'd0;
      repeat (3) @(posedge clk);
      #1 reset_n = 1'b1;
      #1 check("in_ready_after_reset", {31'd0, in_ready}, 32'd1);

      // Hand-computed results
      do_op(OP_DIVU, 32'd100, 32'd7, 0);
      check("divu_100_7", last_out, 32'd14);
      do_op(OP_REM, 32'hFFFF_FFF9, 32'd2, 0);
      check("rem_m7_2", last_out, 32'hFFFF_FFFF);
      do_op(OP_DIV, 32'hFFFF_FFF9, 32'd2, 0);
      check("div_m7_2", last_out, 32'hFFFF_FFFD);
      do_op(OP_DIVU, 32'd5, 32'd0, 0);
      check("divu_by_zero", last_out, 32'hFFFF_FFFF);
      do_op(OP_REMU, 32'd5, 32'd0, 1);
      check("remu_by_zero", last_out, 32'd5);
      do_op(OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 0);
      check("div_overflow", last_out, 32'h8000_0000);
      do_op(OP_REM, 32'h8000_0000, 32'hFFFF_FFFF, 0);
      check("rem_overflow", last_out, 32'd0);
      do_op(OP_DIV, 32'd1000, 32'd10, 10);
      check("div_backpressure", last_out, 32'd100);

      // Reset in the middle of an operation
      while (!in_ready) begin @(posedge clk); #1; end
      in_valid = 1'b1;
      op = OP_DIVU;
      A  = 32'd123456;
      B  = 32'd7;
      @(posedge clk); #1;
      in_valid = 1'b0;
      repeat (10) begin @(posedge clk); #1; end
      reset_n = 1'b0;
      #1;
      check("midrst_busy", {31'd0, busy}, 32'd0);
      check("midrst_out", Out, 32'd0);
      check("midrst_out_valid", {31'd0, out_valid}, 32'd0);
      repeat (2) begin @(posedge clk); #1; end
      reset_n = 1'b1;
      #1 check("midrst_in_ready", {31'd0, in_ready}, 32'd1);
      do_op(OP_DIVU, 32'd9, 32'd3, 0);
      check("divu_9_3", last_out, 32'd3);

      // Randomized traffic
      for (int i = 0; i < 200; i++) rand_op();

      repeat (3) @(posedge clk);
      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
